// File: rtl/imem_pkg.sv
// imem_pkg: state encoding, default NOP and bus field widths shared by the instruction-memory controller
package imem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} imem_state_e;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
endpackage

// File: rtl/imem_line_store.sv
// imem_line_store: valid/tag/data arrays of the direct-mapped cache, built only when IMEM_CACHE_EN is defined
`ifdef IMEM_CACHE_EN
module imem_line_store
  import imem_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_set,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx];
  always_ff @(posedge clk)
    if (rst || flush) valid <= '0;
    else if (wr_en && wr_set) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule
`endif

// File: rtl/imem_ctrl.sv
// imem_ctrl: fetch-port instruction cache with bus fill FSM; cache storage exists only when IMEM_CACHE_EN is defined
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int                LINES    = 64,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_req,
  output logic [DATA_W-1:0] read_value,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);
  imem_state_e state, state_n;
  logic [ADDR_W-3:0] pend;
  logic sample, hit, fill;
  logic [DATA_W-1:0] line_data;
  assign sample = state == IDLE || state == RESP;
  assign fill = state == WAIT && mem_resp_valid;
`ifdef IMEM_CACHE_EN
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic kill, line_valid, unused;
  logic [TAG_W-1:0] line_tag;
  assign unused = ^read_req[1:0];
  imem_line_store #(.LINES(LINES)) u_store (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rd_idx   (read_req[IDX_W+1:2]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_set   (!(kill || flush)),
    .wr_idx   (pend[IDX_W-1:0]),
    .wr_tag   (pend[ADDR_W-3:IDX_W]),
    .wr_data  (mem_resp_data)
  );
  assign hit = line_valid && line_tag == read_req[ADDR_W-1:IDX_W+2];
  // a flush while a fill is outstanding stops that fill from marking its line valid
  always_ff @(posedge clk) kill <= rst || sample ? 1'b0 : kill || flush;
`else
  logic unused;
  assign unused = ^{read_req[1:0], flush};
  assign hit = 1'b0;
  assign line_data = NOP_INST;
`endif
  always_comb begin
    state_n = sample ? (hit ? IDLE : REQ) : state == REQ && mem_req_ready ? WAIT : fill ? RESP : state;
    mem_req_valid = state == REQ;
    mem_req_addr = {pend, 2'b00};
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      read_value <= NOP_INST;
      stall <= 1'b0;
    end else begin
      state <= state_n;
      if (sample) begin
        pend <= read_req[ADDR_W-1:2];
        read_value <= hit ? line_data : NOP_INST;
        stall <= !hit;
      end else if (fill) begin
        read_value <= mem_resp_data;
        stall <= 1'b0;
      end
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: randomized fetch/bus stimulus checked every cycle against a transaction-level cache model
module tb_imem_ctrl;
  localparam int LINES = 64;
`ifdef IMEM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 0, rst = 1, flush = 0, mem_req_ready = 0, mem_resp_valid = 0;
  logic stall, mem_req_valid;
  logic [31:0] read_req = 0, read_value, mem_req_addr, mem_resp_data = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  imem_ctrl #(.LINES(LINES)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_req       (read_req),
    .read_value     (read_value),
    .stall          (stall),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // bus: accepts after a chosen hold, answers after a chosen delay, may inject stray responses
  bit rand_bus = 0, stray_en = 0, outstanding = 0;
  int ready_hold = 0, resp_dly = 0, hold_cnt = 0, tgt = 0, dly = 0, req_cnt = 0, held = 0;
  logic [31:0] bus_addr = 0, first_addr = 0;
  always begin
    @(posedge clk);
    #2;
    mem_resp_valid = 0;
    mem_req_ready = 0;
    if (!mem_req_valid) hold_cnt = 0;
    if (outstanding) begin
      if (dly == 0) begin
        mem_resp_valid = 1;
        mem_resp_data = mem_word(bus_addr);
        outstanding = 0;
      end else dly--;
    end else if (mem_req_valid && !rst) begin
      if (hold_cnt == 0) begin
        tgt = rand_bus ? int'($urandom_range(0, 3)) : ready_hold;
        first_addr = mem_req_addr;
      end else chk("req_addr_stable", mem_req_addr, first_addr);
      if (hold_cnt >= tgt) begin
        mem_req_ready = 1;
        outstanding = 1;
        bus_addr = mem_req_addr;
        dly = rand_bus ? int'($urandom_range(0, 3)) : resp_dly;
        req_cnt++;
        hold_cnt = 0;
      end else begin
        hold_cnt++;
        held++;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      mem_resp_valid = 1;
      mem_resp_data = $urandom;
    end
  end

  // reference: each line remembers which word it holds; a fetch either hits or becomes one fill
  bit started = 0, busy = 0, acc = 0, kill = 0, exp_stall = 0;
  bit cv [LINES];
  logic [29:0] cline [LINES];
  logic [31:0] exp_val = 32'h13, fill_addr = 0;
  int midx, fidx;
  always @(negedge clk) begin
    if (started) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("read_value", read_value, exp_val);
      chk("mem_req_valid", 32'(mem_req_valid), 32'(busy && !acc));
      if (busy && !acc) chk("mem_req_addr", mem_req_addr, fill_addr);
    end
    started = 1;
    midx = int'((read_req >> 2) & (LINES - 1));
    fidx = int'((fill_addr >> 2) & (LINES - 1));
    if (rst) begin
      busy = 0;
      acc = 0;
      exp_stall = 0;
      exp_val = 32'h13;
      foreach (cv[i]) cv[i] = 0;
    end else begin
      if (!busy) begin
        if (CACHE && cv[midx] && cline[midx] == read_req[31:2]) begin
          exp_val = mem_word(read_req);
          exp_stall = 0;
        end else begin
          busy = 1;
          acc = 0;
          kill = 0;
          fill_addr = {read_req[31:2], 2'b00};
          exp_val = 32'h13;
          exp_stall = 1;
        end
      end else begin
        kill = kill | flush;
        if (!acc) acc = mem_req_ready;
        else if (mem_resp_valid) begin
          busy = 0;
          exp_stall = 0;
          exp_val = mem_word(fill_addr);
          if (!kill) begin
            cv[fidx] = 1;
            cline[fidx] = fill_addr[31:2];
          end
        end
      end
      if (flush) foreach (cv[i]) cv[i] = 0;
    end
  end

  task automatic fetch(input logic [31:0] a, input int flush_at, output int lat, output int reqs);
    int r0;
    r0 = req_cnt;
    lat = 0;
    read_req = a;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      flush = (lat == flush_at);
      if (!stall || lat >= 60) break;
    end
    flush = 0;
    chk("fetch_done", 32'(stall), 0);
    reqs = req_cnt - r0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] t;
    t = $urandom_range(0, 3);
    return (t << 8) | (t == 3 ? 32'h8000_0000 : 0) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, reqs;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_read_value", read_value, 32'h13);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, 0);
    fetch(32'h100, 0, lat, reqs);
    chk("cold_latency", 32'(lat), 3);
    chk("cold_value", read_value, 32'hDEAD0100);
    chk("cold_reqs", 32'(reqs), 1);
    chk("cold_bus_addr", bus_addr, 32'h100);
    fetch(32'h100, 0, lat, reqs);
    chk("refetch_latency", 32'(lat), CACHE ? 1 : 3);
    chk("refetch_reqs", 32'(reqs), CACHE ? 0 : 1);
    chk("refetch_value", read_value, 32'hDEAD0100);
    fetch(32'h200, 0, lat, reqs);
    chk("conflict_latency", 32'(lat), 3);
    chk("conflict_value", read_value, 32'hDEAD0200);
    fetch(32'h100, 0, lat, reqs);
    chk("evicted_reqs", 32'(reqs), 1);
    chk("evicted_value", read_value, 32'hDEAD0100);
    ready_hold = 4;
    held = 0;
    fetch(32'h304, 0, lat, reqs);
    ready_hold = 0;
    chk("hold_latency", 32'(lat), 7);
    chk("hold_cycles", 32'(held), 4);
    chk("hold_value", read_value, 32'hDEAD0304);
    resp_dly = 2;
    fetch(32'h408, 2, lat, reqs);
    resp_dly = 0;
    chk("flush_fill_latency", 32'(lat), 5);
    chk("flush_fill_value", read_value, 32'hDEAD0408);
    fetch(32'h408, 0, lat, reqs);
    chk("after_flush_reqs", 32'(reqs), 1);
    chk("after_flush_latency", 32'(lat), 3);
    resp_dly = 3;
    read_req = 32'h50C;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("wait_stall", 32'(stall), 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    resp_dly = 0;
    chk("midfill_rst_value", read_value, 32'h13);
    chk("midfill_rst_stall", 32'(stall), 0);
    chk("midfill_rst_req_valid", 32'(mem_req_valid), 0);
    fetch(32'h50C, 0, lat, reqs);
    chk("abandoned_reqs", 32'(reqs), 1);
    chk("abandoned_latency", 32'(lat), 5);
    chk("abandoned_value", read_value, 32'hDEAD050C);
    rand_bus = 1;
    stray_en = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if (!stall) read_req = rnd_addr();
    end
    rst = 0;
    flush = 0;
    stray_en = 0;
    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
